sample_iter_fsm: RTL and testbench

Sample iterator for the rasterizer pipeline, sitting directly downstream of the bounding-box stage and upstream of the sample-test stage. It accepts one micropolygon per handshake, together with its sample-aligned bounding box. It walks every sample position inside the box in raster order, emitting one sample per cycle. While a box is being walked it stalls the bounding-box stage. Its output register is the single iterator pipe stage (PIPES_ITER = 1).

---
 rtl/sample_iter_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_sample_iter_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_iter_fsm.sv
// sample_iter_fsm
// Sample iterator between the bounding-box stage and the sample-test stage.
// It accepts one micropolygon and its sample-aligned bounding box per
// handshake. It then walks every sample position of the box in raster order,
// one sample per cycle. The output registers form the single iterator stage.
//
// Handshake: the upstream stage presents validTri_R13H with its payload, and
// this block takes it on any clock edge where halt_RnnnnL is high (state WAIT).
// While halt_RnnnnL is low, upstream must hold its outputs, and validTri_R13H
// is ignored.
//
// Optional feature: define RAST_ITER_STATS_EN to build the triangle and
// sample statistics counters. Without it, both count ports are tied to zero.
module sample_iter_fsm #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_R13S,
    input  logic [COLORS*SIGFIG-1:0]        color_R13U,
    input  logic                            validTri_R13H,
    input  logic [2*2*SIGFIG-1:0]           box_R13S,
    input  logic [3:0]                      subSample_RnnnnU,
    output logic                            halt_RnnnnL,
    output logic [VERTS*AXIS*SIGFIG-1:0]    tri_R14S,
    output logic [COLORS*SIGFIG-1:0]        color_R14U,
    output logic [2*SIGFIG-1:0]             sample_R14S,
    output logic                            validSamp_R14H,
    output logic [31:0]                     triCnt_R14U,
    output logic [31:0]                     sampCnt_R14U
);

    localparam int TRI_W   = VERTS * AXIS * SIGFIG;
    localparam int COLOR_W = COLORS * SIGFIG;

    // Step sizes in fixed point: one pixel, then half, quarter, eighth pixel.
    localparam logic [SIGFIG-1:0] ONE      = {{(SIGFIG-1){1'b0}}, 1'b1};
    localparam logic [SIGFIG-1:0] STEP_1X  = ONE << RADIX;
    localparam logic [SIGFIG-1:0] STEP_4X  = ONE << (RADIX - 1);
    localparam logic [SIGFIG-1:0] STEP_16X = ONE << (RADIX - 2);
    localparam logic [SIGFIG-1:0] STEP_64X = ONE << (RADIX - 3);

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    // Registered state and latched primitive data.
    state_t                     state_q;
    logic [TRI_W-1:0]           tri_q;
    logic [COLOR_W-1:0]         color_q;
    logic signed [SIGFIG-1:0]   ll_x_q;
    logic signed [SIGFIG-1:0]   ur_x_q;
    logic signed [SIGFIG-1:0]   ur_y_q;
    logic signed [SIGFIG-1:0]   step_q;
    logic signed [SIGFIG-1:0]   x_q;
    logic signed [SIGFIG-1:0]   y_q;
    logic                       valid_q;

    // Incoming box corners, unpacked from {ur.y, ur.x, ll.y, ll.x}.
    logic signed [SIGFIG-1:0]   in_ll_x;
    logic signed [SIGFIG-1:0]   in_ll_y;
    logic signed [SIGFIG-1:0]   in_ur_x;
    logic signed [SIGFIG-1:0]   in_ur_y;
    logic signed [SIGFIG-1:0]   in_step;

    // Acceptance decisions.
    logic                       acc_degen;
    logic                       acc_single;

    // Walk arithmetic for the next raster position.
    logic signed [SIGFIG-1:0]   x_inc;
    logic                       x_wrap;
    logic signed [SIGFIG-1:0]   next_x;
    logic signed [SIGFIG-1:0]   next_y;
    logic                       next_is_last;

    assign in_ll_x = box_R13S[0*SIGFIG +: SIGFIG];
    assign in_ll_y = box_R13S[1*SIGFIG +: SIGFIG];
    assign in_ur_x = box_R13S[2*SIGFIG +: SIGFIG];
    assign in_ur_y = box_R13S[3*SIGFIG +: SIGFIG];

    // Decode the one-hot sample rate; anything not one-hot falls back to 1x.
    always_comb begin
        in_step = STEP_1X;
        case (subSample_RnnnnU)
            4'b1000: in_step = STEP_1X;
            4'b0100: in_step = STEP_4X;
            4'b0010: in_step = STEP_16X;
            4'b0001: in_step = STEP_64X;
            default: in_step = STEP_1X;
        endcase
    end

    // Classify the incoming box: empty (inverted corners) or a single sample.
    // A box whose span is smaller than one step in both axes has exactly one
    // reachable sample, so it must not enter the walk state.
    always_comb begin
        acc_degen  = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
        acc_single = ((in_ll_x + in_step) > in_ur_x) &&
                     ((in_ll_y + in_step) > in_ur_y);
    end

    // Compute the next raster position and whether it is the final sample.
    // The final sample is the last reachable x on the last reachable row,
    // so the check also works when the span is not a multiple of the step.
    always_comb begin
        x_inc        = x_q + step_q;
        x_wrap       = x_inc > ur_x_q;
        next_x       = x_wrap ? ll_x_q : x_inc;
        next_y       = x_wrap ? (y_q + step_q) : y_q;
        next_is_last = ((next_x + step_q) > ur_x_q) &&
                       ((next_y + step_q) > ur_y_q);
    end

    // Iterator FSM: accept in WAIT, walk the box in TEST, with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= STEP_1X;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (validTri_R13H) begin
                        tri_q   <= tri_R13S;
                        color_q <= color_R13U;
                        ll_x_q  <= in_ll_x;
                        ur_x_q  <= in_ur_x;
                        ur_y_q  <= in_ur_y;
                        step_q  <= in_step;
                        if (acc_degen) begin
                            // Empty box: counted as accepted, nothing emitted.
                            valid_q <= 1'b0;
                            state_q <= WAIT;
                        end else begin
                            x_q     <= in_ll_x;
                            y_q     <= in_ll_y;
                            valid_q <= 1'b1;
                            state_q <= acc_single ? WAIT : TEST;
                        end
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                TEST: begin
                    x_q     <= next_x;
                    y_q     <= next_y;
                    valid_q <= 1'b1;
                    if (next_is_last) begin
                        state_q <= WAIT;
                    end
                end
                default: begin
                    state_q <= WAIT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign halt_RnnnnL    = (state_q == WAIT);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = {y_q, x_q};
    assign validSamp_R14H = valid_q;

`ifdef RAST_ITER_STATS_EN
    logic        stat_accept;
    logic        stat_emit;
    logic [31:0] tri_cnt_q;
    logic [31:0] samp_cnt_q;

    // A sample is counted on the edge that places it in the output register.
    assign stat_accept = (state_q == WAIT) && validTri_R13H;
    assign stat_emit   = (stat_accept && !acc_degen) || (state_q == TEST);

    // Free-running statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_cnt_q  <= '0;
            samp_cnt_q <= '0;
        end else begin
            if (stat_accept) begin
                tri_cnt_q <= tri_cnt_q + 32'd1;
            end
            if (stat_emit) begin
                samp_cnt_q <= samp_cnt_q + 32'd1;
            end
        end
    end

    assign triCnt_R14U  = tri_cnt_q;
    assign sampCnt_R14U = samp_cnt_q;
`else
    assign triCnt_R14U  = 32'd0;
    assign sampCnt_R14U = 32'd0;
`endif

endmodule

// File: tb/tb_sample_iter_fsm.sv
// Directed testbench for sample_iter_fsm.
module tb_sample_iter_fsm;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                         clk;
    logic                         rst_n;
    logic [VERTS*AXIS*SIGFIG-1:0] tri_R13S;
    logic [COLORS*SIGFIG-1:0]     color_R13U;
    logic                         validTri_R13H;
    logic [2*2*SIGFIG-1:0]        box_R13S;
    logic [3:0]                   subSample_RnnnnU;
    logic                         halt_RnnnnL;
    logic [VERTS*AXIS*SIGFIG-1:0] tri_R14S;
    logic [COLORS*SIGFIG-1:0]     color_R14U;
    logic [2*SIGFIG-1:0]          sample_R14S;
    logic                         validSamp_R14H;
    logic [31:0]                  triCnt_R14U;
    logic [31:0]                  sampCnt_R14U;

    int vectors     = 0;
    int miscompares = 0;
    int n_acc       = 0;
    int n_samp      = 0;
    int halt_low    = 0;

    sample_iter_fsm #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .validTri_R13H    (validTri_R13H),
        .box_R13S         (box_R13S),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .triCnt_R14U      (triCnt_R14U),
        .sampCnt_R14U     (sampCnt_R14U)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] smp(input int x, input int y);
        logic [23:0] xs;
        logic [23:0] ys;
        xs = x[23:0];
        ys = y[23:0];
        return {ys, xs};
    endfunction

    function automatic logic [95:0] mk_box(input int llx, input int lly, input int urx, input int ury);
        return {smp(urx, ury), smp(llx, lly)};
    endfunction

    // Check valid/sample/halt; the sample is only compared when valid is expected.
    task automatic chk_out(input string tag, input logic v, input logic [47:0] s, input logic h);
        chk({tag, ".valid"}, 256'(validSamp_R14H), 256'(v));
        if (v) chk({tag, ".sample"}, 256'(sample_R14S), 256'(s));
        chk({tag, ".halt"}, 256'(halt_RnnnnL), 256'(h));
        if (v) n_samp++;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef RAST_ITER_STATS_EN
        chk({tag, ".triCnt"}, 256'(triCnt_R14U), 256'(n_acc));
        chk({tag, ".sampCnt"}, 256'(sampCnt_R14U), 256'(n_samp));
`else
        chk({tag, ".triCnt"}, 256'(triCnt_R14U), 256'(0));
        chk({tag, ".sampCnt"}, 256'(sampCnt_R14U), 256'(0));
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 256'(validSamp_R14H), 256'(0));
        chk({tag, ".halt"}, 256'(halt_RnnnnL), 256'(1));
        chk({tag, ".sample"}, 256'(sample_R14S), 256'(0));
        chk({tag, ".tri"}, 256'(tri_R14S), 256'(0));
        chk({tag, ".color"}, 256'(color_R14U), 256'(0));
        chk_cnt(tag);
    endtask

    initial begin
        logic [215:0] t1;
        logic [71:0]  c1;
        logic [215:0] tk;
        logic [47:0]  walk6 [6];

        t1 = {9{24'h13a5c7}};
        c1 = {3{24'h00ff80}};
        walk6[0] = smp(0, 0);
        walk6[1] = smp(1024, 0);
        walk6[2] = smp(2048, 0);
        walk6[3] = smp(0, 1024);
        walk6[4] = smp(1024, 1024);
        walk6[5] = smp(2048, 1024);

        // Reset state.
        rst_n            = 1'b0;
        tri_R13S         = '0;
        color_R13U       = '0;
        validTri_R13H    = 1'b0;
        box_R13S         = '0;
        subSample_RnnnnU = 4'b1000;
        #3;
        chk_reset("reset");
        #4;
        rst_n = 1'b1;

        // 1x, ll=(0,0), ur=(2048,1024): six samples, halt low for five cycles.
        // validTri and tri toggle during the walk and must be ignored.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b1000;
        box_R13S         = mk_box(0, 0, 2048, 1024);
        tri_R13S         = t1;
        color_R13U       = c1;
        tick();
        n_acc++;
        chk_out("box6.s0", 1'b1, walk6[0], 1'b0);
        chk("box6.tri0", 256'(tri_R14S), 256'(t1));
        chk("box6.color", 256'(color_R14U), 256'(c1));
        if (!halt_RnnnnL) halt_low++;
        for (int i = 1; i < 6; i++) begin
            validTri_R13H = 1'($urandom_range(0, 1));
            tri_R13S      = {9{24'($urandom)}};
            tick();
            chk_out($sformatf("box6.s%0d", i), 1'b1, walk6[i], (i == 5));
            chk($sformatf("box6.tri%0d", i), 256'(tri_R14S), 256'(t1));
            if (!halt_RnnnnL) halt_low++;
        end
        chk("box6.halt_low_cycles", 256'(halt_low), 256'(5));
        validTri_R13H = 1'b0;
        tick();
        chk_out("box6.idle", 1'b0, '0, 1'b1);
        chk("box6.hold", 256'(sample_R14S), 256'(walk6[5]));
        chk_cnt("box6");

        // 4x single-sample boxes back to back: one sample per cycle, no halt.
        for (int k = 0; k < 3; k++) begin
            validTri_R13H    = 1'b1;
            subSample_RnnnnU = 4'b0100;
            box_R13S         = mk_box(5120, 3072, 5120, 3072);
            tk               = {9{24'(k + 7)}};
            tri_R13S         = tk;
            tick();
            n_acc++;
            chk_out($sformatf("single%0d", k), 1'b1, smp(5120, 3072), 1'b1);
            chk($sformatf("single%0d.tri", k), 256'(tri_R14S), 256'(tk));
        end
        validTri_R13H = 1'b0;
        tick();
        chk_out("single.idle", 1'b0, '0, 1'b1);
        chk_cnt("single");

        // 64x, ll=(0,0), ur=(256,0): step 128, three samples.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b0001;
        box_R13S         = mk_box(0, 0, 256, 0);
        tick();
        n_acc++;
        chk_out("x64.s0", 1'b1, smp(0, 0), 1'b0);
        validTri_R13H = 1'b0;
        tick();
        chk_out("x64.s1", 1'b1, smp(128, 0), 1'b0);
        tick();
        chk_out("x64.s2", 1'b1, smp(256, 0), 1'b1);
        tick();
        chk_out("x64.idle", 1'b0, '0, 1'b1);

        // Degenerate box, ur.x = ll.x - 1024 (negative): nothing emitted.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b1000;
        box_R13S         = mk_box(0, 0, -1024, 0);
        tick();
        n_acc++;
        chk_out("degen.acc", 1'b0, '0, 1'b1);
        validTri_R13H = 1'b0;
        tick();
        chk_out("degen.idle", 1'b0, '0, 1'b1);
        chk_cnt("degen");

        // Non-one-hot rate behaves as 1x: (0,0)..(1024,0) gives two samples.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b0011;
        box_R13S         = mk_box(0, 0, 1024, 0);
        tick();
        n_acc++;
        chk_out("nonhot.s0", 1'b1, smp(0, 0), 1'b0);
        validTri_R13H = 1'b0;
        tick();
        chk_out("nonhot.s1", 1'b1, smp(1024, 0), 1'b1);
        tick();
        chk_out("nonhot.idle", 1'b0, '0, 1'b1);

        // Reset pulse in the third cycle of a six-sample box.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b1000;
        box_R13S         = mk_box(0, 0, 2048, 1024);
        tri_R13S         = t1;
        tick();
        chk_out("rst.s0", 1'b1, walk6[0], 1'b0);
        validTri_R13H = 1'b0;
        tick();
        chk_out("rst.s1", 1'b1, walk6[1], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_acc  = 0;
        n_samp = 0;
        chk_reset("rst.async");
        tick();
        chk_reset("rst.held");
        #2;
        rst_n = 1'b1;

        // After release: 1x 2x1 box emits exactly two samples.
        validTri_R13H    = 1'b1;
        subSample_RnnnnU = 4'b1000;
        box_R13S         = mk_box(0, 0, 1024, 0);
        tick();
        n_acc++;
        chk_out("post.s0", 1'b1, smp(0, 0), 1'b0);
        validTri_R13H = 1'b0;
        tick();
        chk_out("post.s1", 1'b1, smp(1024, 0), 1'b1);
        tick();
        chk_out("post.idle", 1'b0, '0, 1'b1);
        chk_cnt("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
